// File: rtl/fir_sample_packer_if.sv
// Sample stream from the byte packer to the FIR core's x input.
// The producer drives data and valid; the consumer drives ready.
interface fir_sample_packer_if;
  logic [31:0] s_dat;
  logic        s_vld;
  logic        s_rdy;

  modport master (output s_dat, output s_vld, input s_rdy);
  modport slave  (input s_dat, input s_vld, output s_rdy);
endinterface

// File: rtl/fir_sample_packer.sv
// Packs strobed pin bytes into little-endian 32-bit samples.
// Samples are buffered in a 2-entry FIFO in front of the FIR core, with pin-timeout and overflow handling.
module fir_sample_packer #(
  parameter int BYTES_PER_SAMPLE = 4,
  parameter bit SIGN_EXTEND      = 1'b1,
  parameter int TIMEOUT_CYC      = 255,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_stb,
  input  logic                 flush,
  fir_sample_packer_if.master  s,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           byte_cnt
);

  localparam int         TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int         WORD_BITS = 8 * BYTES_PER_SAMPLE;
  localparam logic [1:0] LAST_IDX  = 2'(BYTES_PER_SAMPLE - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  function automatic logic [31:0] extend(input logic [31:0] raw);
    logic [31:0] r;
    r = raw;
    for (int i = WORD_BITS; i < 32; i++)
      r[i] = SIGN_EXTEND ? raw[WORD_BITS-1] : 1'b0;
    return r;
  endfunction

  // ---- synchroniser stages: strobe, data and a post-reset fill marker travel together
  logic [SYNC_STAGES-1:0] stb_p;
  logic [SYNC_STAGES-1:0] vld_p;
  logic [7:0]             dat_p [SYNC_STAGES];
  logic                   stb_prev;
  logic                   cap;
  logic [7:0]             cap_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_p <= '0;
      vld_p <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) dat_p[i] <= '0;
    end else begin
      stb_p    <= {stb_p[SYNC_STAGES-2:0], byte_stb};
      vld_p    <= {vld_p[SYNC_STAGES-2:0], 1'b1};
      dat_p[0] <= byte_in;
      for (int i = 1; i < SYNC_STAGES; i++) dat_p[i] <= dat_p[i-1];
    end
  end

  // History is pinned high until the chain has flushed its reset zeros, so a strobe
  // held high through reset must be seen low before it can capture again.
  always_ff @(posedge clk) begin
    if (rst) stb_prev <= 1'b1;
    else     stb_prev <= vld_p[SYNC_STAGES-1] ? stb_p[SYNC_STAGES-1] : 1'b1;
  end

  assign cap      = vld_p[SYNC_STAGES-1] & stb_p[SYNC_STAGES-1] & ~stb_prev;
  assign cap_byte = dat_p[SYNC_STAGES-1];

  // ---- assembler stage
  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [31:0]        acc_q, acc_d;
  logic               push;
  logic [31:0]        push_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          acc_d   = {24'b0, cap_byte};
          timer_d = '0;
          if (BYTES_PER_SAMPLE == 1) begin
            push      = 1'b1;
            push_word = extend(acc_d);
          end else begin
            state_d = COLLECT;
            cnt_d   = 2'd1;
          end
        end
      end
      COLLECT: begin
        if (cap) begin
          acc_d[8*cnt_q +: 8] = cap_byte;
          timer_d             = '0;
          if (cnt_q == LAST_IDX) begin
            push      = 1'b1;
            push_word = extend(acc_d);
            cnt_d     = 2'd0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TMR_W'(TIMEOUT_CYC)) begin
            timer_d = '0;
            cnt_d   = 2'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      timer_d = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk) acc_q <= acc_d;

  // ---- output FIFO stage: head register is s_dat, so it holds its value when empty
  logic [1:0]  count_q;
  logic [31:0] head_q, tail_q;
  logic        pop;

  assign pop = (count_q != 2'd0) && s.s_rdy && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      overflow <= 1'b0;
    end else begin
      case (count_q)
        2'd0: if (push) begin
          head_q  <= push_word;
          count_q <= 2'd1;
        end
        2'd1: case ({push, pop})
          2'b11:   head_q <= push_word;
          2'b01:   count_q <= 2'd0;
          2'b10: begin
            tail_q  <= push_word;
            count_q <= 2'd2;
          end
          default: ;
        endcase
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q  <= push_word;
            else      count_q <= 2'd1;
          end else if (push) begin
            overflow <= 1'b1;
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

  assign s.s_dat  = head_q;
  assign s.s_vld  = (count_q != 2'd0);
  assign busy     = (cnt_q != 2'd0) || (count_q != 2'd0);
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_fir_sample_packer.sv
// Bench for fir_sample_packer: a 4-byte and a 2-byte instance driven from pin-level tasks,
// with every delivered sample scored against a byte-queue model of the packing rules.
module tb_fir_sample_packer;

  localparam int SYNC = 2;
  localparam int TMO  = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_byte, b_byte;
  logic       a_stb, b_stb, a_flush, b_flush;
  logic       a_ovf, b_ovf, a_busy, b_busy;
  logic [1:0] a_cnt, b_cnt;

  fir_sample_packer_if ia ();
  fir_sample_packer_if ib ();

  fir_sample_packer #(.BYTES_PER_SAMPLE(4), .SIGN_EXTEND(1'b1), .TIMEOUT_CYC(TMO), .SYNC_STAGES(SYNC))
    dut_a (.clk(clk), .rst(rst), .byte_in(a_byte), .byte_stb(a_stb), .flush(a_flush),
           .s(ia.master), .overflow(a_ovf), .busy(a_busy), .byte_cnt(a_cnt));

  fir_sample_packer #(.BYTES_PER_SAMPLE(2), .SIGN_EXTEND(1'b1), .TIMEOUT_CYC(TMO), .SYNC_STAGES(SYNC))
    dut_b (.clk(clk), .rst(rst), .byte_in(b_byte), .byte_stb(b_stb), .flush(b_flush),
           .s(ib.master), .overflow(b_ovf), .busy(b_busy), .byte_cnt(b_cnt));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  part [2][$];
  logic [31:0] expq [2][$];
  logic        exp_ovf [2];
  bit          rand_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int bps_of(input int sel);
    return (sel == 0) ? 4 : 2;
  endfunction

  // Reference: little-endian bytes read as a signed bps-byte integer, kept as 32-bit two's complement.
  task automatic model_byte(input int sel, input logic [7:0] b);
    longint v;
    int     bps;
    bps = bps_of(sel);
    part[sel].push_back(b);
    if (part[sel].size() == bps) begin
      v = 0;
      for (int i = 0; i < bps; i++) v += longint'(part[sel][i]) << (8 * i);
      if (v >= (longint'(1) << (8 * bps - 1))) v -= longint'(1) << (8 * bps);
      if (expq[sel].size() >= 2) exp_ovf[sel] = 1'b1;
      else                       expq[sel].push_back(v[31:0]);
      part[sel].delete();
    end
  endtask

  task automatic set_pins(input int sel, input logic stb, input logic [7:0] b);
    if (sel == 0) begin a_stb = stb; a_byte = b; end
    else          begin b_stb = stb; b_byte = b; end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    model_byte(sel, b);
    @(posedge clk); #1;
    set_pins(sel, 1'b0, b);
    @(posedge clk); #1;
    set_pins(sel, 1'b1, b);
    repeat (3) @(posedge clk);
    #1;
    set_pins(sel, 1'b0, b);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ia.s_vld && ia.s_rdy) begin
      if (expq[0].size() == 0) chk("a_vld_unexpected", {31'b0, ia.s_vld}, 32'd0);
      else                     chk("a_dat", ia.s_dat, expq[0].pop_front());
    end
    if (!rst && ib.s_vld && ib.s_rdy) begin
      if (expq[1].size() == 0) chk("b_vld_unexpected", {31'b0, ib.s_vld}, 32'd0);
      else                     chk("b_dat", ib.s_dat, expq[1].pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    a_byte = '0; b_byte = '0; a_stb = 1'b0; b_stb = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    ia.s_rdy = 1'b0; ib.s_rdy = 1'b0;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0;
    wait_cyc(4);
    @(negedge clk);
    chk("rst_sdat", ia.s_dat, 32'h0);
    chk("rst_svld", {31'b0, ia.s_vld}, 32'd0);
    chk("rst_ovf",  {31'b0, a_ovf}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_cnt",  {30'b0, a_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(4);

    // Basic word with latency window, consumer stalled so the beat stays visible.
    send_byte(0, 8'h78); send_byte(0, 8'h56); send_byte(0, 8'h34);
    model_byte(0, 8'h12);
    @(posedge clk); #1; set_pins(0, 1'b0, 8'h12);
    @(posedge clk); #1; set_pins(0, 1'b1, 8'h12);
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    chk("t1_lat_early", {31'b0, ia.s_vld}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_lat_vld", {31'b0, ia.s_vld}, 32'd1);
    chk("t1_dat_const", ia.s_dat, 32'h12345678);
    @(posedge clk); #1;
    set_pins(0, 1'b0, 8'h12);
    ia.s_rdy = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    chk("t1_drained_vld", {31'b0, ia.s_vld}, 32'd0);
    chk("t1_busy", {31'b0, a_busy}, 32'd0);

    // Two-byte samples with sign extension.
    ib.s_rdy = 1'b1;
    send_byte(1, 8'h34); send_byte(1, 8'h82);
    send_byte(1, 8'h01); send_byte(1, 8'h00);
    wait_cyc(6);
    chk("t2_pending", 32'(expq[1].size()), 32'd0);

    // Overflow: three words into a stalled 2-deep FIFO.
    ia.s_rdy = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(0, 8'($urandom));
    wait_cyc(2);
    @(negedge clk);
    chk("t3_ovf", {31'b0, a_ovf}, {31'b0, exp_ovf[0]});
    chk("t3_vld", {31'b0, ia.s_vld}, 32'd1);
    chk("t3_head", ia.s_dat, expq[0][0]);
    @(posedge clk); #1;
    ia.s_rdy = 1'b1;
    wait_cyc(6);
    @(negedge clk);
    chk("t3_ovf_sticky", {31'b0, a_ovf}, {31'b0, exp_ovf[0]});
    chk("t3_pending", 32'(expq[0].size()), 32'd0);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    exp_ovf[0] = 1'b0;
    @(negedge clk);
    chk("t3_flush_ovf", {31'b0, a_ovf}, {31'b0, exp_ovf[0]});
    chk("t3_flush_vld", {31'b0, ia.s_vld}, 32'd0);

    // Flush discards a buffered word.
    ia.s_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
    @(negedge clk);
    chk("t3b_vld", {31'b0, ia.s_vld}, 32'd1);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    expq[0].delete();
    @(negedge clk);
    chk("t3b_flush_vld", {31'b0, ia.s_vld}, 32'd0);
    chk("t3b_flush_busy", {31'b0, a_busy}, 32'd0);
    @(posedge clk); #1;
    ia.s_rdy = 1'b1;

    // Timeout drops a partial word.
    send_byte(0, 8'($urandom)); send_byte(0, 8'($urandom));
    wait_cyc(TMO - 10);
    @(negedge clk);
    chk("t4_cnt_hold", {30'b0, a_cnt}, 32'd2);
    wait_cyc(20);
    part[0].delete();
    @(negedge clk);
    chk("t4_cnt_timeout", {30'b0, a_cnt}, 32'd0);
    chk("t4_busy", {31'b0, a_busy}, 32'd0);
    send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33); send_byte(0, 8'h44);
    wait_cyc(4);
    chk("t4_pending", 32'(expq[0].size()), 32'd0);

    // Strobe held high through reset release.
    @(posedge clk); #1;
    rst = 1'b1;
    set_pins(0, 1'b1, 8'h00);
    wait_cyc(4);
    rst = 1'b0;
    part[0].delete(); part[1].delete(); expq[0].delete(); expq[1].delete();
    wait_cyc(8);
    @(negedge clk);
    chk("t5_nocap", {30'b0, a_cnt}, 32'd0);
    @(posedge clk); #1;
    set_pins(0, 1'b0, 8'h5A);
    wait_cyc(4);
    set_pins(0, 1'b1, 8'h5A);
    model_byte(0, 8'h5A);
    wait_cyc(5);
    @(negedge clk);
    chk("t5_cap_one", {30'b0, a_cnt}, 32'd1);
    @(posedge clk); #1;
    set_pins(0, 1'b0, 8'h5A);
    wait_cyc(3);

    // Reset mid-word, then a fresh word.
    send_byte(0, 8'($urandom)); send_byte(0, 8'($urandom));
    @(negedge clk);
    chk("t6_cnt_pre", {30'b0, a_cnt}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    part[0].delete();
    @(negedge clk);
    chk("t6_cnt_rst", {30'b0, a_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
    wait_cyc(4);
    chk("t6_pending", 32'(expq[0].size()), 32'd0);

    // Randomised traffic on both instances with a random consumer.
    rand_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 12; w++) begin
          for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
          for (int i = 0; i < 2; i++) send_byte(1, 8'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ia.s_rdy = 1'($urandom_range(0, 1));
          ib.s_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    ia.s_rdy = 1'b1;
    ib.s_rdy = 1'b1;
    wait_cyc(10);
    @(negedge clk);
    chk("rnd_a_pending", 32'(expq[0].size()), 32'd0);
    chk("rnd_b_pending", 32'(expq[1].size()), 32'd0);
    chk("rnd_a_ovf", {31'b0, a_ovf}, {31'b0, exp_ovf[0]});
    chk("rnd_b_ovf", {31'b0, b_ovf}, {31'b0, exp_ovf[1]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
